// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared sizing helpers and legal channel range for the round-robin mux
package mux_rr_pkg;
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  function automatic int sel_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search with an optional per-packet lock
// Ports: clk, rst_n (sync, active-low); req[N] requests; advance = granted
// request accepted this cycle; lock = accepted beat is not the packet's last;
// gnt[N] one-hot grant; gnt_idx binary grant index.
module rr_arbiter import mux_rr_pkg::*; #(
  parameter int N = 8,
  parameter int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  input  logic            lock,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);
  logic [SELW-1:0] ptr_q, ptr_d, lidx_q, lidx_d, nxt;
  logic            lock_q, lock_d, found;
  always_comb begin
    int c;
    c = 0;
    found = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      // wrap at N rather than 2^SELW so non-power-of-two N never skips or aliases
      c = (int'(ptr_q) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        gnt_idx = SELW'(c);
      end
    end
    // a locked packet owns the grant even while its producer is idle
    if (lock_q) begin
      found = req[lidx_q];
      gnt_idx = lidx_q;
    end
  end
  assign gnt    = found ? (N'(1) << gnt_idx) : '0;
  assign nxt    = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
  assign lock_d = advance ? lock : lock_q;
  assign lidx_d = advance ? gnt_idx : lidx_q;
  assign ptr_d  = (advance && !lock) ? nxt : ptr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      lidx_q <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      lidx_q <= lidx_d;
      lock_q <= lock_d;
    end
  end
endmodule

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-way W-bit registered mux with valid/ready handshakes and round-robin arbitration
// Ports: clk, rst_n (sync, active-low); in_valid[N], in_data[N*W] (channel i at
// [i*W +: W]), in_ready[N] one-hot/zero; out_valid, out_data[W], out_sel[SELW],
// out_ready. Define MUX_RR_N_LOCK_EN to add in_last[N] and lock the grant to a
// channel until its last beat is accepted.
module mux_rr_n import mux_rr_pkg::*; #(
  parameter int N = 8,
  parameter int W = 32,
  parameter int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
`ifdef MUX_RR_N_LOCK_EN
  ,
  input  logic [N-1:0]    in_last
`endif
);
  logic [N-1:0]    gnt;
  logic [SELW-1:0] gnt_idx, out_sel_q, out_sel_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d, free, accept, lock;
  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (accept),
    .lock    (lock),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
`ifdef MUX_RR_N_LOCK_EN
  assign lock = !in_last[gnt_idx];
`else
  assign lock = 1'b0;
`endif
  assign free        = !out_valid_q || out_ready;
  assign in_ready    = (rst_n && free) ? gnt : '0;
  assign accept      = |in_ready;
  assign out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  assign out_data_d  = accept ? in_data[int'(gnt_idx)*W +: W] : out_data_q;
  assign out_sel_d   = accept ? gnt_idx : out_sel_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed table-driven checks of the round-robin registered mux
module tb_mux_rr_n;
  typedef struct {
    logic        rst_n;
    logic [7:0]  vld;
    logic        ordy;
    logic [7:0]  ir;
    logic        ov;
    logic [2:0]  sel;
    logic [31:0] data;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n, out_ready, out_valid;
  logic [7:0]  in_valid, in_ready;
  logic [255:0] in_data;
  logic [31:0] out_data;
  logic [2:0]  out_sel;
  logic        rst5_n, ordy5, ov5;
  logic [4:0]  v5, ir5;
  logic [39:0] d5;
  logic [7:0]  od5;
  logic [2:0]  os5;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
`ifdef MUX_RR_N_LOCK_EN
  logic [7:0] in_last = 8'hFF;
`endif
  always #5 clk = ~clk;
  mux_rr_n #(.N(8), .W(32)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
`ifdef MUX_RR_N_LOCK_EN
    , .in_last(in_last)
`endif
  );
  mux_rr_n #(.N(5), .W(8)) u5 (
    .clk(clk), .rst_n(rst5_n), .in_valid(v5), .in_data(d5),
    .in_ready(ir5), .out_valid(ov5), .out_data(od5),
    .out_sel(os5), .out_ready(ordy5)
`ifdef MUX_RR_N_LOCK_EN
    , .in_last(5'h1F)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(logic r, logic [7:0] v, logic o, logic [7:0] ir,
                              logic ov, logic [2:0] s, logic [31:0] d);
    vec_t t;
    t.rst_n = r; t.vld = v; t.ordy = o; t.ir = ir; t.ov = ov; t.sel = s; t.data = d;
    return t;
  endfunction
  task automatic step8(input logic r, input logic [7:0] v, input logic o,
                       input logic [7:0] ir, input logic ov, input logic [2:0] s,
                       input logic [31:0] d, input string tag);
    @(negedge clk);
    rst_n = r; in_valid = v; out_ready = o;
    #1 chk({tag, " in_ready"}, 32'(in_ready), 32'(ir));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " out_sel"}, 32'(out_sel), 32'(s));
    chk({tag, " out_data"}, out_data, d);
  endtask
  task automatic step5(input logic r, input logic [4:0] v, input logic [4:0] ir,
                       input logic [2:0] s, input string tag);
    @(negedge clk);
    rst5_n = r; v5 = v; ordy5 = 1'b1;
    #1 chk({tag, " in_ready5"}, 32'(ir5), 32'(ir));
    @(posedge clk);
    #1;
    chk({tag, " out_sel5"}, 32'(os5), 32'(s));
    chk({tag, " out_data5"}, 32'(od5), r ? 32'h50 + 32'(s) : 32'h0);
  endtask
  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1;
    rst5_n = 1'b0; v5 = '0; ordy5 = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'h50 + 8'(i);
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 0, 0, 32'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'hFF, 1, 8'(1 << i), 1, 3'(i), 32'hA000_0000 + 32'(i)));
    tbl.push_back(mk(1, 8'hFF, 1, 8'h01, 1, 0, 32'hA000_0000));
    tbl.push_back(mk(1, 8'h08, 1, 8'h08, 1, 3, 32'hA000_0003));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'h20, 0, 8'h00, 1, 3, 32'hA000_0003));
    tbl.push_back(mk(1, 8'h20, 1, 8'h20, 1, 5, 32'hA000_0005));
    tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 5, 32'hA000_0005));
    tbl.push_back(mk(1, 8'hFF, 1, 8'h40, 1, 6, 32'hA000_0006));
    tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 1, 6, 32'hA000_0006));
    tbl.push_back(mk(0, 8'hFF, 0, 8'h00, 0, 0, 32'h0));
    tbl.push_back(mk(1, 8'hFF, 0, 8'h01, 1, 0, 32'hA000_0000));
    for (int i = 0; i < tbl.size(); i++)
      step8(tbl[i].rst_n, tbl[i].vld, tbl[i].ordy, tbl[i].ir, tbl[i].ov,
            tbl[i].sel, tbl[i].data, $sformatf("vec%0d", i));
    step5(0, 5'h1F, 5'h00, 0, "w_rst");
    step5(1, 5'b01000, 5'b01000, 3, "w_ch3");
    step5(1, 5'b10010, 5'b10000, 4, "w_g4a");
    step5(1, 5'b10010, 5'b00010, 1, "w_g1");
    step5(1, 5'b10010, 5'b10000, 4, "w_g4b");
`ifdef MUX_RR_N_LOCK_EN
    step8(0, 8'h00, 1, 8'h00, 0, 0, 32'h0, "l_rst");
    step8(1, 8'h02, 1, 8'h02, 1, 1, 32'hA000_0001, "l_ch1");
    in_last = 8'h00;
    step8(1, 8'h05, 1, 8'h04, 1, 2, 32'hA000_0002, "l_b0");
    step8(1, 8'h01, 1, 8'h00, 0, 2, 32'hA000_0002, "l_gap");
    step8(1, 8'h05, 1, 8'h04, 1, 2, 32'hA000_0002, "l_b1");
    in_last = 8'hFF;
    step8(1, 8'h05, 1, 8'h04, 1, 2, 32'hA000_0002, "l_b2");
    step8(1, 8'h05, 1, 8'h01, 1, 0, 32'hA000_0000, "l_rel");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-way, W-bit registered multiplexer with per-input valid/ready handshakes and round-robin arbitration. It is the sequential successor to the fixed 8-way 32-bit combinational mux. It sits wherever several producers (decode, ALU, memory-read paths) compete for one downstream consumer and the selection must be fair and back-pressured. It is not a driver-selected combinational path.

## Interface
- `N`, default 8: number of input channels, legal range 2..16.
- `W`, default 32: data width in bits, minimum 1.
- `SELW`, default `$clog2(N)`: derived width of the channel index. It is never overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  N  bit i asserted means channel i offers a word.
- `in_data`  in  N*W  flat bus; channel i occupies bits [i*W +: W].
- `in_ready`  out  N  one-hot or zero; bit i asserted means channel i's word is accepted this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  W  registered selected word.
- `out_sel`  out  SELW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `in_last`  in  N  present only with `MUX_RR_N_LOCK_EN`; marks the final beat of a packet.

## Operation
- **Reset:** while `rst_n` is 0 at a clock edge:
  - `out_valid`, `out_data`, `out_sel` and `ptr` are all cleared to 0.
  - The lock is released.
  - `in_ready` is held at 0 combinationally during reset.
- **Output state:** a one-entry output register plus a round-robin pointer `ptr` (SELW bits).
- **Output slot free:** `free = !out_valid || out_ready`.
- **Grant search:** the grant goes to the first i with `in_valid[i]`, searching i = ptr, ptr+1, …, ptr+N-1 modulo N. The modulo wraps at N, not at 2^SELW, for non-power-of-two N. Grant is none if no input is valid.
- **`in_ready`:** `in_ready[g] = free`; every other bit is 0. `in_ready` may depend combinationally on `in_valid` and `out_ready`. Producers must not make `in_valid` depend on `in_ready`.
- **Accept:** when `in_valid[g] && in_ready[g]`:
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod N`.
- **No accept:** if `out_ready` is high and nothing is accepted, `out_valid <= 0`. `out_data` and `out_sel` hold their stale values.
- **Simultaneous drain and fill:** when `out_ready` and an accept happen in the same cycle, the register is refilled with no bubble. Full throughput is 1 word/cycle.
- **Stall:** while `out_valid && !out_ready`, all outputs are held stable and all `in_ready` bits are 0.
- **Idle:** `ptr` is unchanged on cycles with no accept.
- **Reset mid-transfer:** a word held in the output register is discarded. The consumer must not count it.

## Timing
- Latency is 1 cycle from accept edge to `out_valid`.
- Zero combinational path from `in_data` to `out_data`.
- Combinational paths exist from `in_valid`/`out_ready`/`ptr` to `in_ready`. These are the only combinational paths.
- **Fairness:** with all N inputs continuously valid and `out_ready` = 1, the grant sequence is 0,1,…,N-1,0,… Each channel is served at least once every N accepts.

## Configuration
- **`MUX_RR_N_LOCK_EN` defined:**
  - The `in_last` port exists.
  - After an accept from channel g with `in_last[g]` = 0, the grant is locked to g until a beat from g with `in_last[g]` = 1 is accepted.
  - While locked, other channels see `in_ready` = 0 even if g is not valid.
  - `ptr` advances only on the accepted last beat.
  - Reset clears the lock.
- **Not defined:** the port is absent and every accept is a single-beat packet. Behaviour matches the unlocked description above.

## Structure
- **Shared package `mux_rr_pkg`:**
  - `function automatic int sel_width(int n)`, wrapping `$clog2` with a minimum of 1.
  - Localparams for the legal N range.
- **Sub-module `rr_arbiter #(N)`:**
  - Inputs: `clk`, `rst_n`, `req[N]`, `advance`, optional `lock`.
  - Outputs: one-hot `gnt[N]` and the binary `gnt_idx`.
  - Owns `ptr` and the lock state.
- **`mux_rr_n`** owns the output register, the data mux and the handshake glue.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with all `in_valid` = 1 → `out_valid` = 0, `in_ready` = 0, `out_data` = 0. On the first cycle after release, `in_ready` = 8'b0000_0001.
- **Round-robin:** N=8, W=32, all valid, `in_data[i]` = 32'hA000_0000+i, `out_ready` = 1 → `out_sel` sequence is 0..7,0 on consecutive cycles, `out_data` = 32'hA000_0000..32'hA000_0007, and `out_valid` never drops.
- **Back-pressure:** one word from channel 3, then `out_ready` = 0 for 4 cycles → `out_data`/`out_sel` are stable and `in_ready` = 0. Raising `out_ready` with channel 5 valid → `out_sel` = 5 on the next cycle, with no gap.
- **Wrap and sparse requests:** N=5, `ptr` = 4, only channels 1 and 4 valid → grant 4, then 1, then 4.
- **Lock (`MUX_RR_N_LOCK_EN`):** channel 2 sends 3 beats (`in_last` = 0,0,1) while channel 0 is always valid → `out_sel` = 2,2,2, then 0. `in_ready[0]` stays 0 for the whole packet, including a cycle where `in_valid[2]` = 0.
- **Reset mid-stream:** assert `rst_n` = 0 while `out_valid` = 1 and `out_ready` = 0 → `out_valid` = 0 on the next edge, and `ptr` restarts at 0.
